controller_decode: RTL and testbench



---
 rtl/controller_decode_if.sv | 11 +
 rtl/controller_decode.sv | 66 ++++++
 tb/tb_controller_decode.sv | 105 ++++++++++
 3 files changed

// File: rtl/controller_decode_if.sv
// Opcode-in / control-bundle-out signal group between the ID stage and the main decoder.
interface controller_decode_if;
  logic [5:0] OpCode;
  logic [8:0] EX;
  logic [4:0] M;
  logic [3:0] WB;
  logic       ID;

  modport master (output OpCode, input EX, M, WB, ID);
  modport slave  (input OpCode, output EX, M, WB, ID);
endinterface

// File: rtl/controller_decode.sv
// Main control decoder: registers EX/M/WB/ID bundles one cycle after the opcode.
// Macro CONTROLLER_SPECIAL2_EN enables decode of opcode 011100 (SPECIAL2).
module controller_decode (
  input  logic                Clk,
  input  logic                Rst_n,
  controller_decode_if.slave  dec
);

  logic [8:0] w_ex, r_ex;
  logic [4:0] w_m,  r_m;
  logic [3:0] w_wb, r_wb;
  logic       w_id, r_id;

  // Unknown (including X/Z) opcodes fall through to the all-zero NOP bundle.
  always_comb begin
    w_ex = '0;
    w_m  = '0;
    w_wb = '0;
    w_id = 1'b0;
    case (dec.OpCode)
      6'b000000: begin w_ex = 9'b010000001; w_wb = 4'b1000; end
      6'b000001: begin w_ex = 9'b000001100; w_m  = 5'b10000; end
      6'b000010: begin w_id = 1'b1; end
      6'b000011: begin w_ex = 9'b100000000; w_wb = 4'b1010; w_id = 1'b1; end
      6'b000100: begin w_ex = 9'b000001000; w_m  = 5'b10000; end
      6'b000101: begin w_ex = 9'b000001001; w_m  = 5'b10000; end
      6'b000110: begin w_ex = 9'b000001010; w_m  = 5'b10000; end
      6'b000111: begin w_ex = 9'b000001011; w_m  = 5'b10000; end
      6'b001000: begin w_ex = 9'b001000000; w_wb = 4'b1000; end
      6'b001010: begin w_ex = 9'b001000011; w_wb = 4'b1000; end
      6'b001100: begin w_ex = 9'b001100100; w_wb = 4'b1000; end
      6'b001101: begin w_ex = 9'b001100101; w_wb = 4'b1000; end
      6'b001110: begin w_ex = 9'b001100110; w_wb = 4'b1000; end
`ifdef CONTROLLER_SPECIAL2_EN
      6'b011100: begin w_ex = 9'b010000111; w_wb = 4'b1000; end
`endif
      6'b100000: begin w_ex = 9'b001000000; w_m = 5'b01010; w_wb = 4'b1101; end
      6'b100001: begin w_ex = 9'b001000000; w_m = 5'b01001; w_wb = 4'b1101; end
      6'b100011: begin w_ex = 9'b001000000; w_m = 5'b01000; w_wb = 4'b1100; end
      6'b101000: begin w_ex = 9'b001000000; w_m = 5'b00110; end
      6'b101001: begin w_ex = 9'b001000000; w_m = 5'b00101; end
      6'b101011: begin w_ex = 9'b001000000; w_m = 5'b00100; end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_ex <= '0;
      r_m  <= '0;
      r_wb <= '0;
      r_id <= 1'b0;
    end else begin
      r_ex <= w_ex;
      r_m  <= w_m;
      r_wb <= w_wb;
      r_id <= w_id;
    end
  end

  assign dec.EX = r_ex;
  assign dec.M  = r_m;
  assign dec.WB = r_wb;
  assign dec.ID = r_id;

endmodule

// File: tb/tb_controller_decode.sv
// Directed-vector bench for controller_decode; compares packed {EX,M,WB,ID} bundles.
module tb_controller_decode;

  logic Clk;
  logic Rst_n;
  controller_decode_if dec_if ();

  controller_decode dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .dec   (dec_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned n_checks;
  int unsigned n_bad;

`ifdef CONTROLLER_SPECIAL2_EN
  localparam logic [18:0] SP2_EXP = {9'b010000111, 5'b00000, 4'b1000, 1'b0};
`else
  localparam logic [18:0] SP2_EXP = '0;
`endif

  logic [5:0]  sw_op  [20];
  logic [18:0] sw_exp [20];

  task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Apply opcode/reset away from the edge, then sample #1 after the capturing edge.
  task automatic step(input logic [5:0] op, input logic rst_n, input string tag,
                      input logic [18:0] exp);
    @(negedge Clk);
    dec_if.OpCode = op;
    Rst_n = rst_n;
    @(posedge Clk);
    #1;
    check_eq(tag, {dec_if.EX, dec_if.M, dec_if.WB, dec_if.ID}, exp);
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;

    sw_op  = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
               6'b000101, 6'b000110, 6'b000111, 6'b001000, 6'b001010,
               6'b001100, 6'b001101, 6'b001110, 6'b011100, 6'b100000,
               6'b100001, 6'b100011, 6'b101000, 6'b101001, 6'b101011};
    sw_exp = '{{9'b010000001, 5'b00000, 4'b1000, 1'b0},
               {9'b000001100, 5'b10000, 4'b0000, 1'b0},
               {9'b000000000, 5'b00000, 4'b0000, 1'b1},
               {9'b100000000, 5'b00000, 4'b1010, 1'b1},
               {9'b000001000, 5'b10000, 4'b0000, 1'b0},
               {9'b000001001, 5'b10000, 4'b0000, 1'b0},
               {9'b000001010, 5'b10000, 4'b0000, 1'b0},
               {9'b000001011, 5'b10000, 4'b0000, 1'b0},
               {9'b001000000, 5'b00000, 4'b1000, 1'b0},
               {9'b001000011, 5'b00000, 4'b1000, 1'b0},
               {9'b001100100, 5'b00000, 4'b1000, 1'b0},
               {9'b001100101, 5'b00000, 4'b1000, 1'b0},
               {9'b001100110, 5'b00000, 4'b1000, 1'b0},
               SP2_EXP,
               {9'b001000000, 5'b01010, 4'b1101, 1'b0},
               {9'b001000000, 5'b01001, 4'b1101, 1'b0},
               {9'b001000000, 5'b01000, 4'b1100, 1'b0},
               {9'b001000000, 5'b00110, 4'b0000, 1'b0},
               {9'b001000000, 5'b00101, 4'b0000, 1'b0},
               {9'b001000000, 5'b00100, 4'b0000, 1'b0}};

    Rst_n = 1'b0;
    dec_if.OpCode = 6'b100011;

    step(6'b100011, 1'b0, "reset_edge0", '0);
    step(6'b100011, 1'b0, "reset_edge1", '0);
    step(6'b100011, 1'b1, "release_lw", {9'b001000000, 5'b01000, 4'b1100, 1'b0});

    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        // Mid-sweep reset pulse: zero bundle for that edge, then resume with same opcode.
        step(sw_op[i], 1'b0, "midsweep_reset", '0);
      end
      step(sw_op[i], 1'b1, $sformatf("sweep_op%06b", sw_op[i]), sw_exp[i]);
    end

    step(6'b000011, 1'b1, "b2b_jal", {9'b100000000, 5'b00000, 4'b1010, 1'b1});
    step(6'b000010, 1'b1, "b2b_j",   {9'b000000000, 5'b00000, 4'b0000, 1'b1});

    step(6'b111111, 1'b1, "unknown_111111", '0);
    step(6'b000000, 1'b1, "rtype_between", {9'b010000001, 5'b00000, 4'b1000, 1'b0});
    step(6'b001001, 1'b1, "unknown_001001", '0);
    step(6'b011100, 1'b1, "special2", SP2_EXP);
    step(6'b101011, 1'b1, "sw_after_special2", {9'b001000000, 5'b00100, 4'b0000, 1'b0});

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
